// File: rtl/gigatron_spi_target_if.sv
// Bundle of the CPU-facing SPI pins and the back-end byte stream of the SPI target.
interface gigatron_spi_target_if;
  logic [7:0]  ctrl;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic        selected;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        underrun;
  logic [15:0] byte_cnt;

  // Driver side: the CPU ctrl port plus the back-end byte source.
  modport master (
    output ctrl, mosi, tx_data, tx_valid,
    input  miso, miso_oe, selected, rx_data, rx_valid, tx_ready, underrun, byte_cnt
  );

  // The SPI target itself.
  modport slave (
    input  ctrl, mosi, tx_data, tx_valid,
    output miso, miso_oe, selected, rx_data, rx_valid, tx_ready, underrun, byte_cnt
  );
endinterface

// File: rtl/gigatron_spi_target.sv
// SPI mode-0 target watching one /SS bit of the Gigatron ctrl port.
// Exchanges bytes MSB-first, with a one-entry tx holding buffer feeding the shifter.
// ctrl is a registered CPU output in the same clock domain, so it is used without synchronisers.
module gigatron_spi_target #(
  parameter int unsigned SS_INDEX  = 0,
  parameter logic        IDLE_MISO = 1'b1
) (
  input logic                  clock,
  input logic                  rst,
  gigatron_spi_target_if.slave bus
);
  localparam int DATA_W  = 8;
  localparam int SEL_BIT = 2 + SS_INDEX;

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e              state_q;
  logic                sclk_q;
  logic [DATA_W-1:0]   shreg_q;
  logic [DATA_W-1:0]   rxsh_q;
  logic [2:0]          bit_cnt_q;
  logic                bnd_q;
  logic                miso_q;
  logic                miso_oe_q;
  logic [DATA_W-1:0]   rx_data_q;
  logic                rx_valid_q;
  logic                underrun_q;
  logic [15:0]         byte_cnt_q;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic                full_q, full_d;

  logic                sel, rise, fall, consume, load;
  logic [DATA_W-1:0]   next_byte;
  logic                unused_ctrl;

  assign sel       = ~bus.ctrl[SEL_BIT];
  assign rise      = bus.ctrl[0] & ~sclk_q;
  assign fall      = ~bus.ctrl[0] & sclk_q;
  // A byte starts either on select assertion or on the fall right after the 8th rise.
  assign consume   = ((state_q == IDLE) && sel) ||
                     ((state_q == ACTIVE) && sel && fall && bnd_q);
  assign load      = bus.tx_valid && !full_q;
  // An empty buffer at byte start sends all-ones and flags an underrun.
  assign next_byte = full_q ? buf_q : {DATA_W{1'b1}};
  assign unused_ctrl = ^bus.ctrl;

  // Holding buffer next state: consume at byte start, then accept a new byte if it was empty.
  always_comb begin
    buf_d  = buf_q;
    full_d = full_q;
    if (consume) full_d = 1'b0;
    if (load) begin
      buf_d  = bus.tx_data;
      full_d = 1'b1;
    end
  end

  // Select FSM, shifters, counters and all registered outputs.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= IDLE;
      sclk_q     <= 1'b0;
      bit_cnt_q  <= '0;
      bnd_q      <= 1'b0;
      miso_q     <= IDLE_MISO;
      miso_oe_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      byte_cnt_q <= '0;
      full_q     <= 1'b0;
    end else begin
      sclk_q     <= bus.ctrl[0];
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      full_q     <= full_d;
      case (state_q)
        IDLE: begin
          if (sel) begin
            state_q    <= ACTIVE;
            shreg_q    <= next_byte;
            miso_q     <= next_byte[DATA_W-1];
            miso_oe_q  <= 1'b1;
            underrun_q <= ~full_q;
            bit_cnt_q  <= '0;
            bnd_q      <= 1'b0;
            byte_cnt_q <= '0;
          end
        end
        ACTIVE: begin
          if (!sel) begin
            // Deselect drops any partial byte; byte_cnt and the buffer are kept.
            state_q   <= IDLE;
            miso_q    <= IDLE_MISO;
            miso_oe_q <= 1'b0;
            bit_cnt_q <= '0;
            bnd_q     <= 1'b0;
          end else if (rise) begin
            rxsh_q    <= {rxsh_q[DATA_W-2:0], bus.mosi};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_q  <= {rxsh_q[DATA_W-2:0], bus.mosi};
              rx_valid_q <= 1'b1;
              byte_cnt_q <= byte_cnt_q + 16'd1;
              bnd_q      <= 1'b1;
            end
          end else if (fall) begin
            if (bnd_q) begin
              shreg_q    <= next_byte;
              miso_q     <= next_byte[DATA_W-1];
              underrun_q <= ~full_q;
              bnd_q      <= 1'b0;
            end else begin
              shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
              miso_q  <= shreg_q[DATA_W-2];
            end
          end
        end
      endcase
    end
  end

  // Holding buffer data register; validity is tracked by full_q.
  always_ff @(posedge clock) begin
    buf_q <= buf_d;
  end

  assign bus.miso     = miso_q;
  assign bus.miso_oe  = miso_oe_q;
  assign bus.selected = (state_q == ACTIVE);
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.tx_ready = ~full_q;
  assign bus.underrun = underrun_q;
  assign bus.byte_cnt = byte_cnt_q;
endmodule

// File: tb/tb_gigatron_spi_target.sv
// Scoreboard bench for gigatron_spi_target acting as the CPU-side SPI master.
module tb_gigatron_spi_target;
  logic clock = 1'b0;
  logic rst;
  always #5 clock = ~clock;

  gigatron_spi_target_if bus();

  gigatron_spi_target #(.SS_INDEX(0), .IDLE_MISO(1'b1)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0]  d;
    logic [15:0] cnt;
  } rx_t;

  int n_checks = 0;
  int n_fail   = 0;

  rx_t  exp_rx[$];
  logic exp_miso[$];
  rx_t  mon_e;
  logic mon_b;

  // Reference model: a one-entry buffer and a byte stream.
  bit          mdl_full = 1'b0;
  logic [7:0]  mdl_buf  = 8'h00;
  logic [7:0]  mdl_cur  = 8'hFF;
  logic [7:0]  mdl_rx   = 8'h00;
  int          mdl_bits = 0;
  logic [15:0] mdl_cnt  = 16'h0000;
  int          exp_underruns  = 0;
  int          seen_underruns = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic mdl_byte_start();
    if (mdl_full) begin
      mdl_cur  = mdl_buf;
      mdl_full = 1'b0;
    end else begin
      mdl_cur = 8'hFF;
      exp_underruns++;
    end
    mdl_bits = 0;
  endtask

  task automatic offer(input logic [7:0] b);
    check("tx_ready_before_offer", {31'd0, bus.tx_ready}, {31'd0, !mdl_full});
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    tick(1);
    bus.tx_valid = 1'b0;
    mdl_full = 1'b1;
    mdl_buf  = b;
  endtask

  task automatic select_ss();
    bus.ctrl[2] = 1'b0;
    tick(2);
    mdl_cnt = 16'h0000;
    mdl_byte_start();
    check("miso_oe_selected", {31'd0, bus.miso_oe}, 32'd1);
  endtask

  task automatic deselect_ss();
    bus.ctrl[2] = 1'b1;
    tick(2);
    mdl_bits = 0;
    check("miso_oe_deselected", {31'd0, bus.miso_oe}, 32'd0);
    check("miso_idle", {31'd0, bus.miso}, 32'd1);
    check("byte_cnt_hold", {16'd0, bus.byte_cnt}, {16'd0, mdl_cnt});
  endtask

  // One SCLK period; optionally offers a tx byte in the same cycle SCLK falls.
  task automatic spi_bit(input logic b, input bit do_load = 1'b0, input logic [7:0] ld = 8'h00);
    bus.mosi = b;
    tick(2);
    exp_miso.push_back(mdl_cur[7 - mdl_bits]);
    mdl_rx = {mdl_rx[6:0], b};
    mdl_bits++;
    if (mdl_bits == 8) begin
      mdl_cnt = mdl_cnt + 16'd1;
      exp_rx.push_back('{mdl_rx, mdl_cnt});
    end
    bus.ctrl[0] = 1'b1;
    tick(2);
    bus.ctrl[0] = 1'b0;
    if (do_load) begin
      bus.tx_data  = ld;
      bus.tx_valid = 1'b1;
      tick(1);
      bus.tx_valid = 1'b0;
      tick(1);
    end else begin
      tick(2);
    end
    if (mdl_bits == 8) mdl_byte_start();
    if (do_load) begin
      mdl_full = 1'b1;
      mdl_buf  = ld;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  // Monitor: received bytes and underrun pulses.
  always @(negedge clock) begin
    if (bus.underrun === 1'b1) seen_underruns++;
    if (bus.rx_valid === 1'b1) begin
      if (exp_rx.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected: got rx_valid with rx_data=%0h, required no rx_valid", bus.rx_data);
      end else begin
        mon_e = exp_rx.pop_front();
        check("rx_data", {24'd0, bus.rx_data}, {24'd0, mon_e.d});
        check("byte_cnt", {16'd0, bus.byte_cnt}, {16'd0, mon_e.cnt});
      end
    end
  end

  // Monitor: MISO as the CPU samples it on each SCLK rise.
  always @(posedge bus.ctrl[0]) begin
    if (exp_miso.size() != 0) begin
      mon_b = exp_miso.pop_front();
      check("miso_bit", {31'd0, bus.miso}, {31'd0, mon_b});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    bus.ctrl     = 8'h3C;
    bus.mosi     = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    rst          = 1'b1;
    tick(2);
    check("rst_miso",     {31'd0, bus.miso},     32'd1);
    check("rst_miso_oe",  {31'd0, bus.miso_oe},  32'd0);
    check("rst_selected", {31'd0, bus.selected}, 32'd0);
    check("rst_rx_data",  {24'd0, bus.rx_data},  32'd0);
    check("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
    check("rst_underrun", {31'd0, bus.underrun}, 32'd0);
    check("rst_byte_cnt", {16'd0, bus.byte_cnt}, 32'd0);
    rst = 1'b0;
    tick(2);

    // Single exchange: send A5, receive 3C.
    offer(8'hA5);
    check("tx_ready_full", {31'd0, bus.tx_ready}, {31'd0, !mdl_full});
    select_ss();
    check("selected", {31'd0, bus.selected}, 32'd1);
    spi_byte(8'h3C);
    deselect_ss();

    // Back-to-back: only one byte buffered, 16 bits clocked.
    offer(8'h12);
    select_ss();
    spi_byte(8'($urandom));
    spi_byte(8'($urandom));
    deselect_ss();
    tick(1);
    check("underruns_b2b", seen_underruns, exp_underruns);

    // Abort after 5 rises, then a clean 0x81 transaction.
    select_ss();
    for (int i = 0; i < 5; i++) spi_bit(1'($urandom));
    deselect_ss();
    select_ss();
    spi_byte(8'h81);
    deselect_ss();

    // Wrong select: only /SS2 low while SCLK toggles.
    r = 8'($urandom);
    offer(r);
    bus.ctrl[4] = 1'b0;
    tick(2);
    for (int i = 0; i < 8; i++) begin
      bus.mosi    = 1'($urandom);
      bus.ctrl[0] = 1'b1;
      tick(2);
      bus.ctrl[0] = 1'b0;
      tick(2);
    end
    check("wrongsel_miso_oe",  {31'd0, bus.miso_oe},  32'd0);
    check("wrongsel_selected", {31'd0, bus.selected}, 32'd0);
    check("wrongsel_tx_ready", {31'd0, bus.tx_ready}, {31'd0, !mdl_full});
    bus.ctrl[4] = 1'b1;
    tick(2);

    // Buffer pressure: 0x55 buffered, 0x66 held on tx_valid.
    select_ss();
    offer(8'h55);
    bus.tx_data  = 8'h66;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 4; i++) spi_bit(1'($urandom));
    check("pressure_not_accepted", {31'd0, bus.tx_ready}, {31'd0, !mdl_full});
    for (int i = 0; i < 4; i++) spi_bit(1'($urandom));
    // The boundary consumed 0x55; the held 0x66 is taken on the following cycle.
    mdl_full = 1'b1;
    mdl_buf  = 8'h66;
    bus.tx_valid = 1'b0;
    check("pressure_accepted", {31'd0, bus.tx_ready}, {31'd0, !mdl_full});
    spi_byte(8'($urandom));
    spi_byte(8'($urandom));
    deselect_ss();

    // Load in the same cycle as the boundary fall.
    select_ss();
    for (int i = 0; i < 7; i++) spi_bit(1'($urandom));
    spi_bit(1'($urandom), 1'b1, 8'hC3);
    check("fall_load_tx_ready", {31'd0, bus.tx_ready}, {31'd0, !mdl_full});
    spi_byte(8'($urandom));
    deselect_ss();

    // Randomised transactions, including partial bytes.
    for (int t = 0; t < 8; t++) begin
      if (!mdl_full && $urandom_range(0, 1) == 1) offer(8'($urandom));
      select_ss();
      for (int i = 0, n = $urandom_range(1, 20); i < n; i++) spi_bit(1'($urandom));
      deselect_ss();
    end

    tick(3);
    check("rx_pending",   exp_rx.size(),   32'd0);
    check("miso_pending", exp_miso.size(), 32'd0);
    check("underruns_total", seen_underruns, exp_underruns);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
